pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
// - Parametrised successor to the fixed inter-stage registers (IF/ID ... MEM/WB). Carries a data
//   payload plus a control bundle through STAGES back-to-pressured register slots.
// - Adds what the fixed registers lack: valid/ready handshake, stall via back-pressure, flush,
//   bubble-safe control zeroing and a registered ready with full throughput (skid slots).
// - Sits between any two core pipeline stages. MEM->WB uses DATA_W=32*6, CTRL_W=4+5 (rd).
// PARAMETERS
// - DATA_W  default 32  payload width (PC, ALU result, load data ... concatenated by the user).
// - CTRL_W  default 8   control bundle width (RegWrite, branch, jalr, load mux, rd ...).
// - STAGES  default 1   number of chained slots, >=1; each slot adds 1 cycle of latency.
// PORTS
// - clk_i        in   1                 clock, all state updates on rising edge
// - reset_i      in   1                 synchronous, active-high reset
// - flush_i      in   1                 kill every in-flight entry (branch/jalr redirect)
// - in_valid_i   in   1                 upstream entry present
// - in_ready_o   out  1                 chain accepts an entry this cycle (registered)
// - in_data_i    in   DATA_W            upstream payload
// - in_ctrl_i    in   CTRL_W            upstream control bundle
// - out_valid_o  out  1                 downstream entry present
// - out_ready_i  in   1                 downstream consumes this cycle
// - out_data_o   out  DATA_W            payload of head entry
// - out_ctrl_o   out  CTRL_W            control of head entry; forced 0 when out_valid_o=0
// - count_o      out  $clog2(2*STAGES+1) entries currently held
// BEHAVIOUR
// - Transfer: in side on in_valid_i&in_ready_o; out side on out_valid_o&out_ready_i.
// - Each slot = main reg + skid reg (capacity 2). Slot ready = ~skid_valid, a flop, never
//   combinational from out_ready_i. Chain capacity 2*STAGES.
// - Latency: entry accepted at edge N appears at out at edge N+STAGES if never stalled.
//   Throughput 1/cycle with out_ready_i held 1.
// - Slot update: main empty or consumed -> main loads from skid if skid valid, else from input.
//   Main full and not consumed while input arrives -> input goes to skid, ready drops next cycle.
//   Skid drains into main on the first consume; ready rises the cycle after.
// - Order strictly FIFO; no entry dropped or duplicated except by flush.
// - Flush: at the edge with flush_i=1 all main/skid valids clear, count_o->0; an input
//   handshaked that same cycle is discarded; an output handshaked that cycle counts as consumed.
//   in_ready_o=1 the cycle after flush. Data regs are not cleared by flush.
// - Bubble safety: out_ctrl_o = valid ? ctrl : '0 (combinational gate on the head), so a
//   bubble never asserts RegWrite etc. out_data_o is don't-care when invalid.
// - Reset: at an edge with reset_i=1 all valids, data and ctrl regs clear to 0; after reset
//   out_valid_o=0, out_ctrl_o=0, out_data_o=0, in_ready_o=1, count_o=0. Reset beats flush,
//   discards in-flight entries mid-transfer.
// - Simultaneous push+pop at full capacity: pop frees main, skid moves up, ready rises next
//   cycle (input not accepted that cycle since ready was 0).
// - count_o: +1 on in handshake, -1 on out handshake, both -> unchanged; never exceeds 2*STAGES.
// STRUCTURE
// - Package pipe_pkg: typedef of MEM/WB ctrl bundle struct (pcBranch, RegWrite, Con_Jalr,
//   LoadMux, rd[4:0]) and localparam CTRL_W_MEMWB=9; users cast to/from CTRL_W vectors.
// - Sub-module pipe_skid_slot (one main+skid slot, params DATA_W/CTRL_W, same handshake ports
//   plus flush/reset); top = generate chain of STAGES slots + ctrl gate + occupancy counter.
// TESTING
// - Reset: hold reset_i=1 2 cycles with in_valid_i=1 -> out_valid_o=0, out_ctrl_o=0,
//   in_ready_o=1, count_o=0.
// - Streaming, STAGES=2, out_ready_i=1: push data 1..8 back-to-back -> out 1..8 at edges
//   N+2..N+9, in_ready_o never 0.
// - Stall: STAGES=1, out_ready_i=0, push A,B -> in_ready_o=0 after B, count_o=2; raise
//   out_ready_i -> A then B out on consecutive cycles, in_ready_o=1 one cycle after A.
// - Flush mid-stream: 3 entries held, flush_i=1 with in_valid_i=1 (data C) -> next cycle
//   out_valid_o=0, count_o=0, C never appears; following push D emerges normally.
// - Bubble ctrl: in_ctrl_i=9'h1FF with in_valid_i=0 -> out_ctrl_o stays 0 every cycle.
// - Random valid/ready (10k cycles) vs. reference queue model: order, no loss, count_o match.

Source files
------------

// File: rtl/pipe_stage_chain_pkg.sv
// Shared types for the pipeline register chain: MEM/WB control bundle layout and
// the occupancy-counter width helper.
package pipe_pkg;

  typedef struct packed {
    logic       pc_branch;
    logic       reg_write;
    logic       con_jalr;
    logic       load_mux;
    logic [4:0] rd;
  } memwb_ctrl_t;

  localparam int CTRL_W_MEMWB = 9;

  // Counter must represent 0 .. 2*stages inclusive.
  function automatic int count_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_skid_slot.sv
// One pipeline slot: main register plus skid register, so ready is a flop and
// throughput stays at one entry per cycle under back-pressure.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              push;
  logic              pop;
  logic              main_free;

  assign push      = in_valid_i & ~skid_valid;
  assign pop       = main_valid & out_ready_i;
  assign main_free = ~main_valid | pop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else begin
      if (flush_i) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= push;
        end
      end else if (push) begin
        skid_valid <= 1'b1;
      end

      // Data regs follow the same steering; flush leaves their contents alone.
      if (main_free) begin
        if (skid_valid) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end else if (push) begin
          main_data <= in_data_i;
          main_ctrl <= in_ctrl_i;
        end
      end else if (push) begin
        skid_data <= in_data_i;
        skid_ctrl <= in_ctrl_i;
      end
    end
  end

  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign out_ctrl_o  = main_ctrl;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised inter-stage register chain: STAGES skid slots in series, a
// bubble-safe control gate on the head and an occupancy counter.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int STAGES = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [DATA_W-1:0]           in_data_i,
  input  logic [CTRL_W-1:0]           in_ctrl_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [CTRL_W-1:0]           out_ctrl_o,
  output logic [count_w(STAGES)-1:0]  count_o
);

  localparam int CNT_W = count_w(STAGES);

  logic [STAGES:0]   valid;
  logic [STAGES:0]   ready;
  logic [DATA_W-1:0] data [STAGES+1];
  logic [CTRL_W-1:0] ctrl [STAGES+1];
  logic              in_fire;
  logic              out_fire;
  logic [CNT_W-1:0]  count;

  assign valid[0]      = in_valid_i;
  assign data[0]       = in_data_i;
  assign ctrl[0]       = in_ctrl_i;
  assign ready[STAGES] = out_ready_i;

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_skid_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slot (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .flush_i     (flush_i),
      .in_valid_i  (valid[g]),
      .in_ready_o  (ready[g]),
      .in_data_i   (data[g]),
      .in_ctrl_i   (ctrl[g]),
      .out_valid_o (valid[g+1]),
      .out_ready_i (ready[g+1]),
      .out_data_o  (data[g+1]),
      .out_ctrl_o  (ctrl[g+1])
    );
  end

  assign in_fire  = in_valid_i & ready[0];
  assign out_fire = valid[STAGES] & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (in_fire & ~out_fire) begin
      count <= count + CNT_W'(1);
    end else if (out_fire & ~in_fire) begin
      count <= count - CNT_W'(1);
    end
  end

  assign in_ready_o  = ready[0];
  assign out_valid_o = valid[STAGES];
  assign out_data_o  = data[STAGES];
  // A bubble must never present live control (e.g. RegWrite) downstream.
  assign out_ctrl_o  = valid[STAGES] ? ctrl[STAGES] : '0;
  assign count_o     = count;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench: a STAGES=1 and a STAGES=2 chain, each with a queue
// scoreboard, plus a directed vector table and hand-written corner sequences.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = CTRL_W_MEMWB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]    a_count;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [2:0]    b_count;

  pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .STAGES(1)) dut_a (
    .clk_i(clk), .reset_i(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_data_i(a_in_data), .in_ctrl_i(a_in_ctrl),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_data_o(a_out_data), .out_ctrl_o(a_out_ctrl), .count_o(a_count)
  );

  pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .STAGES(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_data_i(b_in_data), .in_ctrl_i(b_in_ctrl),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_data_o(b_out_data), .out_ctrl_o(b_out_ctrl), .count_o(b_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: push on accepted input, pop on output handshake, model count = queue size.
  logic [DW+CW-1:0] qa[$];
  logic [DW+CW-1:0] qb[$];
  logic [DW+CW-1:0] ea, eb;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      check("a_count", 64'(a_count), 64'(qa.size()));
      if (!a_out_valid) check("a_bubble_ctrl", 64'(a_out_ctrl), 64'(0));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          check("a_pop_empty", 64'(1), 64'(0));
        end else begin
          ea = qa.pop_front();
          check("a_out_data", 64'(a_out_data), 64'(ea[DW+CW-1:CW]));
          check("a_out_ctrl", 64'(a_out_ctrl), 64'(ea[CW-1:0]));
        end
      end
      if (a_in_valid && a_in_ready && !a_flush) qa.push_back({a_in_data, a_in_ctrl});
      if (a_flush) qa.delete();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      check("b_count", 64'(b_count), 64'(qb.size()));
      if (!b_out_valid) check("b_bubble_ctrl", 64'(b_out_ctrl), 64'(0));
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          check("b_pop_empty", 64'(1), 64'(0));
        end else begin
          eb = qb.pop_front();
          check("b_out_data", 64'(b_out_data), 64'(eb[DW+CW-1:CW]));
          check("b_out_ctrl", 64'(b_out_ctrl), 64'(eb[CW-1:0]));
        end
      end
      if (b_in_valid && b_in_ready && !b_flush) qb.push_back({b_in_data, b_in_ctrl});
      if (b_flush) qb.delete();
    end
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_d;
    logic [1:0]    e_cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  logic [CW-1:0] e_ctrl;

  initial begin
    // STAGES=1 vectors: inputs for one cycle, expected state right after the edge.
    tbl[0]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA,  2'd1};
    tbl[1]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  2'd2};
    tbl[2]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  2'd2};
    tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB,  2'd1};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    tbl[5]  = '{1'b1, 32'hD,  1'b0, 1'b0, 1'b1, 1'b1, 32'hD,  2'd1};
    tbl[6]  = '{1'b1, 32'hE,  1'b0, 1'b0, 1'b0, 1'b1, 32'hD,  2'd2};
    tbl[7]  = '{1'b1, 32'hF,  1'b1, 1'b0, 1'b1, 1'b1, 32'hE,  2'd1};
    tbl[8]  = '{1'b1, 32'hF,  1'b1, 1'b0, 1'b1, 1'b1, 32'hF,  2'd1};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    tbl[10] = '{1'b1, 32'h1A, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1A, 2'd1};
    tbl[11] = '{1'b1, 32'h1B, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1A, 2'd2};
    tbl[12] = '{1'b1, 32'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0};
    tbl[13] = '{1'b1, 32'h1D, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1D, 2'd1};
    tbl[14] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};

    // Reset held two cycles with traffic offered on both chains.
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h55; a_in_ctrl = 9'h1FF; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h66; b_in_ctrl = 9'h1FF; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_valid", 64'(a_out_valid), 64'(0));
    check("a_rst_ctrl",  64'(a_out_ctrl),  64'(0));
    check("a_rst_data",  64'(a_out_data),  64'(0));
    check("a_rst_ready", 64'(a_in_ready),  64'(1));
    check("a_rst_count", 64'(a_count),     64'(0));
    check("b_rst_valid", 64'(b_out_valid), 64'(0));
    check("b_rst_ctrl",  64'(b_out_ctrl),  64'(0));
    check("b_rst_ready", 64'(b_in_ready),  64'(1));
    check("b_rst_count", 64'(b_count),     64'(0));
    rst = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_in_ctrl = '0; b_in_ctrl = '0;

    for (int i = 0; i < NV; i++) begin
      a_in_valid  = tbl[i].iv;
      a_in_data   = tbl[i].d;
      a_in_ctrl   = tbl[i].d[CW-1:0] ^ 9'h155;
      a_out_ready = tbl[i].ordy;
      a_flush     = tbl[i].fl;
      @(posedge clk);
      #1;
      e_ctrl = tbl[i].e_vld ? (tbl[i].e_d[CW-1:0] ^ 9'h155) : '0;
      check("tbl_ready", 64'(a_in_ready),  64'(tbl[i].e_rdy));
      check("tbl_valid", 64'(a_out_valid), 64'(tbl[i].e_vld));
      check("tbl_count", 64'(a_count),     64'(tbl[i].e_cnt));
      check("tbl_ctrl",  64'(a_out_ctrl),  64'(e_ctrl));
      if (tbl[i].e_vld) check("tbl_data", 64'(a_out_data), 64'(tbl[i].e_d));
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;

    // STAGES=2 streaming: entry pushed in cycle i is presented in cycle i+2.
    b_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b_in_valid = (i < 8);
      b_in_data  = 32'(i + 1);
      b_in_ctrl  = 9'(i + 1);
      @(negedge clk);
      if (i < 8) check("b_stream_ready", 64'(b_in_ready), 64'(1));
      if (i >= 2 && i < 10) begin
        check("b_stream_valid", 64'(b_out_valid), 64'(1));
        check("b_stream_data",  64'(b_out_data),  64'(i - 1));
      end else begin
        check("b_stream_idle", 64'(b_out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;

    // Flush with three entries held and a new entry offered in the same cycle.
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 32'h100 + 32'(i);
      b_in_ctrl  = 9'h0A0 + 9'(i);
      @(posedge clk);
      #1;
    end
    check("b_held_count", 64'(b_count),    64'(3));
    check("b_held_ready", 64'(b_in_ready), 64'(1));
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = 32'hC0C0; b_in_ctrl = 9'h1C0;
    @(posedge clk);
    #1;
    b_flush = 1'b0; b_in_valid = 1'b0;
    check("b_flush_valid", 64'(b_out_valid), 64'(0));
    check("b_flush_count", 64'(b_count),     64'(0));
    check("b_flush_ready", 64'(b_in_ready),  64'(1));
    b_in_valid = 1'b1; b_in_data = 32'hD0D0; b_in_ctrl = 9'h0D0; b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    check("b_post_flush_empty", 64'(b_out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("b_d_valid", 64'(b_out_valid), 64'(1));
    check("b_d_data",  64'(b_out_data),  64'(32'hD0D0));
    @(posedge clk);
    #1;
    check("b_d_gone", 64'(b_out_valid), 64'(0));

    // Bubble: all-ones control offered without valid never reaches the output.
    b_in_valid = 1'b0; b_in_ctrl = 9'h1FF;
    for (int i = 0; i < 6; i++) begin
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = $urandom;
      @(negedge clk);
      check("b_bubble_out_ctrl", 64'(b_out_ctrl), 64'(0));
      @(posedge clk);
      #1;
    end

    // Random valid/ready/flush on both chains, with one reset mid-traffic.
    for (int c = 0; c < 10000; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      a_in_ctrl   = 9'($urandom);
      a_flush     = ($urandom_range(0, 63) == 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = $urandom;
      b_in_ctrl   = 9'($urandom);
      b_flush     = ($urandom_range(0, 63) == 0);
      rst         = (c == 5000);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("a_drain_count", 64'(a_count),     64'(0));
    check("a_drain_valid", 64'(a_out_valid), 64'(0));
    check("b_drain_count", 64'(b_count),     64'(0));
    check("b_drain_valid", 64'(b_out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
